alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
//   Shares one combinational ALU between NREQ requesters (one per core).
//   Round-robin grant, operand/opcode latching, a registered result and
//   per-requester valid/ready response handshakes.
//   Sits between the cores' execute-stage issue logic and a single alu instance.
//
// PARAMETERS
//   NREQ   2    number of requesters (2..8)
//   PTRW   $clog2(NREQ)   round-robin pointer / grant index width (derived)
//
// PORTS
//   CLK          in   1        clock, rising edge
//   RST          in   1        synchronous reset, active-high
//   req_valid    in   NREQ     request present, one bit per requester
//   req_aluop    in   NREQ*4   aluop_t per requester; slice i = [4i+3:4i]
//   req_porta    in   NREQ*32  operand A per requester
//   req_portb    in   NREQ*32  operand B per requester
//   req_ready    out  NREQ     request accepted this cycle (one-hot or zero)
//   resp_valid   out  NREQ     result available for requester i (one-hot or zero)
//   resp_ready   in   NREQ     requester i consumes result
//   resp_out     out  32       result word (shared by all requesters)
//   resp_flags   out  3        {negative, overflow, zero}
//   alu_op       out  4        to ALU ALUOP
//   alu_porta    out  32       to ALU porta
//   alu_portb    out  32       to ALU portb
//   alu_out      in   32       from ALU out
//   alu_negative in   1        from ALU negative
//   alu_overflow in   1        from ALU overflow
//   alu_zero     in   1        from ALU zero
//   perf_clr     in   1        clear grant counters (optional feature)
//   grant_cnt    out  NREQ*32  grants per requester (optional feature)
//
// BEHAVIOUR
//   - FSM states: IDLE, EXEC, RESP.
//   - IDLE
//     - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready[winner] = 1 combinationally in this cycle.
//     - On the edge: latch winner index into gnt, latch its aluop/porta/portb, go EXEC.
//     - No valid requests: stay in IDLE; req_ready = 0.
//   - EXEC
//     - alu_op/porta/portb are driven from the latched registers in every state.
//     - On the edge: capture alu_out and the three flags into resp regs, go RESP.
//   - RESP
//     - resp_valid[gnt] = 1; resp_out and resp_flags are held stable.
//     - On resp_ready[gnt]: rr_ptr <= (gnt+1) mod NREQ, go IDLE.
//     - resp_ready of any other requester is ignored.
//   - Timing
//     - Accept in cycle T gives resp_valid from T+2; minimum 3 cycles per op.
//     - A resp_ready already high in the first RESP cycle completes the handshake that cycle.
//   - Handshake rules
//     - A requester holds valid and operands stable until req_ready.
//     - req_valid changes during EXEC/RESP are ignored.
//     - A requester whose valid drops before grant is simply not served.
//   - Fairness: with all requesters permanently valid, grants rotate 0,1,..,NREQ-1,0.
//   - Reset (any state, including mid-transaction)
//     - state IDLE, rr_ptr 0; latched op/operands 0, so alu_* = 0.
//     - resp_out 0, resp_flags 0, resp_valid 0, req_ready 0.
//     - An in-flight transaction is dropped with no response.
//
// CONFIGURATION
//   ALU_ARB_PERF_EN defined:
//     - grant_cnt[i] increments on every req_ready[i] cycle and saturates at 32'hFFFF_FFFF.
//     - perf_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
//     - RST zeroes all counters.
//   ALU_ARB_PERF_EN undefined:
//     - Ports remain present; grant_cnt is tied to 0 and perf_clr is ignored.
//     - No counter flops are inferred.
//
// TESTING
//   1. Req0 ADD 0x7FFFFFFF+1, accepted at T
//        -> resp_valid[0] at T+2; out 0x80000000; flags {1,1,0}.
//   2. Req0 and Req1 valid every cycle, resp_ready tied high, 4 ops
//        -> grants 0,1,0,1; each op 3 cycles.
//   3. Req1 SUB 5-5 with resp_ready[1] low for 10 cycles
//        -> resp held; out 0; zero flag 1; no new grant; Req0 stalled.
//   4. RST asserted in EXEC
//        -> next cycle all outputs 0; no resp_valid; a later request is served normally.
//   5. resp_ready[0] pulsed while resp_valid[1]
//        -> ignored; FSM stays in RESP.
//   6. ALU_ARB_PERF_EN: 3 grants to req0, then perf_clr coincident with a grant
//        -> grant_cnt[0] = 3, then 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NREQ requesters.
//
// Round-robin arbitration in IDLE, operand/opcode latching on accept, one EXEC cycle while
// the ALU evaluates the latched operands, then a registered result held in RESP until the
// granted requester raises resp_ready.
//
// Ports:
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       per-requester request handshake (req_ready one-hot or zero)
//   req_aluop/porta/portb     packed per-requester opcode (4b) and operands (32b)
//   resp_valid/resp_ready     per-requester response handshake (resp_valid one-hot or zero)
//   resp_out, resp_flags      registered result and {negative, overflow, zero}
//   alu_op/porta/portb        to the shared ALU, driven from the latched registers
//   alu_out/negative/...      from the shared ALU
//   perf_clr, grant_cnt       grant counters, present only with ALU_ARB_PERF_EN defined;
//                             otherwise grant_cnt reads 0 and perf_clr is ignored
module alu_arbiter #(
  parameter int unsigned  NREQ = 2,
  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*4-1:0]  req_aluop,
  input  logic [NREQ*32-1:0] req_porta,
  input  logic [NREQ*32-1:0] req_portb,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [31:0]        resp_out,
  output logic [2:0]         resp_flags,
  output logic [3:0]         alu_op,
  output logic [31:0]        alu_porta,
  output logic [31:0]        alu_portb,
  input  logic [31:0]        alu_out,
  input  logic               alu_negative,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  input  logic               perf_clr,
  output logic [NREQ*32-1:0] grant_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0] gnt_q, gnt_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic [2:0]      flags_q, flags_d;

  logic            win_found;
  logic [PTRW-1:0] win_idx;
  logic [3:0]      win_op;
  logic [31:0]     win_a, win_b;
  logic            resp_hit;

  // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_op    = '0;
    win_a     = '0;
    win_b     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_found && req_valid[i] && ((32'(rr_ptr_q) + k) % NREQ) == i) begin
          win_found = 1'b1;
          win_idx   = PTRW'(i);
          win_op    = req_aluop[4*i +: 4];
          win_a     = req_porta[32*i +: 32];
          win_b     = req_portb[32*i +: 32];
        end
      end
    end
  end

  // Only the granted requester's resp_ready matters.
  always_comb begin
    resp_hit = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q == PTRW'(i) && resp_ready[i]) resp_hit = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d   = win_idx;
          op_d    = win_op;
          a_d     = win_a;
          b_d     = win_b;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = alu_out;
        flags_d = {alu_negative, alu_overflow, alu_zero};
        state_d = StResp;
      end
      StResp: begin
        if (resp_hit) begin
          rr_ptr_d = (gnt_q == PTRW'(NREQ - 1)) ? '0 : gnt_q + PTRW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // req_ready is masked during RST so nothing appears accepted in a reset cycle.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i]  = (state_q == StIdle) && !RST && win_found && (win_idx == PTRW'(i));
      resp_valid[i] = (state_q == StResp) && (gnt_q == PTRW'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_porta  = a_q;
  assign alu_portb  = b_q;
  assign resp_out   = res_q;
  assign resp_flags = flags_q;

`ifdef ALU_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [31:0] cnt_q;
    // Clear has priority over a same-cycle grant; counting saturates.
    always_ff @(posedge CLK) begin
      if (RST || perf_clr) begin
        cnt_q <= '0;
      end else if (req_ready[i] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign grant_cnt[32*i +: 32] = cnt_q;
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign grant_cnt       = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level model (round-robin pointer, arithmetic ALU function).
module tb_alu_arbiter;

  localparam int unsigned NREQ = 3;

  logic               CLK, RST;
  logic [NREQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*4-1:0]  req_aluop;
  logic [NREQ*32-1:0] req_porta, req_portb, grant_cnt;
  logic [31:0]        resp_out, alu_porta, alu_portb, alu_out;
  logic [2:0]         resp_flags;
  logic [3:0]         alu_op;
  logic               alu_negative, alu_overflow, alu_zero, perf_clr;

  int n_total = 0;
  int n_bad   = 0;
  int rr      = 0;
  int gcnt[NREQ];

  alu_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_aluop(req_aluop), .req_porta(req_porta),
    .req_portb(req_portb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_flags(resp_flags),
    .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb),
    .alu_out(alu_out), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .perf_clr(perf_clr), .grant_cnt(grant_cnt)
  );

  // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, else pass A. Returns {neg, ovf, zero, out}.
  function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {r[31], v, (r == 32'd0), r};
  endfunction

  logic [34:0] alu_res;
  assign alu_res      = alu_f(alu_op, alu_porta, alu_portb);
  assign alu_out      = alu_res[31:0];
  assign alu_zero     = alu_res[32];
  assign alu_overflow = alu_res[33];
  assign alu_negative = alu_res[34];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_aluop[4*i +: 4]  = 4'($urandom_range(0, 5));
      req_porta[32*i +: 32] = $urandom;
      req_portb[32*i +: 32] = ($urandom_range(0, 3) == 0) ? req_porta[32*i +: 32] : $urandom;
    end
  endtask

  // One full transaction starting in IDLE at posedge+1; response withheld for 'hold' cycles
  // while every other requester's resp_ready is high.
  task automatic run_txn(input logic [NREQ-1:0] v, input int hold, input bit rnd);
    int          w;
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    logic [34:0] e;
    if (rnd) rand_ops();
    req_valid = v;
    #1;
    w = pick(v, rr);
    check_eq("req_ready", req_ready, oh(w));
    eop = req_aluop[4*w +: 4];
    ea  = req_porta[32*w +: 32];
    eb  = req_portb[32*w +: 32];
    e   = alu_f(eop, ea, eb);
    step();
    gcnt[w]++;
    req_valid = NREQ'($urandom);
    rand_ops();
    #1;
    check_eq("exec_ready", req_ready, '0);
    check_eq("exec_rvalid", resp_valid, '0);
    check_eq("alu_op", alu_op, eop);
    check_eq("alu_porta", alu_porta, ea);
    check_eq("alu_portb", alu_portb, eb);
    step();
    check_eq("resp_valid", resp_valid, oh(w));
    check_eq("resp_out", resp_out, e[31:0]);
    check_eq("resp_flags", resp_flags, e[34:32]);
    for (int h = 0; h < hold; h++) begin
      resp_ready = ~oh(w);
      req_valid  = '1;
      step();
      check_eq("hold_valid", resp_valid, oh(w));
      check_eq("hold_out", resp_out, e[31:0]);
      check_eq("hold_flags", resp_flags, e[34:32]);
      check_eq("hold_ready", req_ready, '0);
    end
    resp_ready = oh(w) | NREQ'($urandom);
    req_valid  = '0;
    step();
    rr = (w + 1) % NREQ;
    resp_ready = '0;
    #1;
    check_eq("done_rvalid", resp_valid, '0);
  endtask

  initial begin
    int ngr, last, w;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    RST = 1'b1; req_valid = '0; resp_ready = '0; perf_clr = 1'b0;
    req_aluop = '0; req_porta = '0; req_portb = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_rvalid", resp_valid, '0);
    check_eq("rst_out", resp_out, 32'd0);
    check_eq("rst_flags", resp_flags, 3'd0);
    check_eq("rst_aluop", alu_op, 4'd0);
    check_eq("rst_porta", alu_porta, 32'd0);
    RST = 1'b0;
    step();

    // Signed-overflowing ADD from requester 0.
    req_aluop[3:0] = 4'd0; req_porta[31:0] = 32'h7FFF_FFFF; req_portb[31:0] = 32'd1;
    run_txn(3'b001, 0, 1'b0);

    // Requesters 0 and 1 always valid, responses always consumed: grants alternate 3 apart.
    rand_ops();
    req_valid = 3'b011; resp_ready = '1;
    ngr = 0; last = 0;
    #1;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      if (req_ready != '0) begin
        w = pick(req_valid, rr);
        check_eq("fair_gnt", req_ready, oh(w));
        if (ngr > 0) check_eq("fair_gap", 64'(c - last), 64'd3);
        last = c; ngr++; rr = (w + 1) % NREQ; gcnt[w]++;
      end
      step();
    end
    check_eq("fair_count", 64'(ngr), 64'd4);
    req_valid = '0;
    step(); step();
    resp_ready = '0;
    #1;
    check_eq("fair_idle", resp_valid, '0);

    // SUB 5-5 from requester 1 held for 10 cycles with requester 0 waiting.
    req_aluop[7:4] = 4'd1; req_porta[63:32] = 32'd5; req_portb[63:32] = 32'd5;
    run_txn(3'b010, 10, 1'b0);

    // Reset during EXEC drops the transaction.
    rand_ops();
    req_valid = 3'b001;
    step();
    RST = 1'b1; req_valid = '0;
    step();
    RST = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", resp_valid, '0);
    check_eq("mid_rst_ready", req_ready, '0);
    check_eq("mid_rst_out", resp_out, 32'd0);
    check_eq("mid_rst_flags", resp_flags, 3'd0);
    check_eq("mid_rst_aluop", alu_op, 4'd0);
    check_eq("mid_rst_portb", alu_portb, 32'd0);
    step();
    check_eq("mid_rst_rvalid2", resp_valid, '0);
    rr = 0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    run_txn(3'b111, 1, 1'b1);

    for (int n = 0; n < 30; n++) run_txn(NREQ'($urandom_range(1, 7)), $urandom_range(0, 3), 1'b1);

`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) check_eq("cnt_total", grant_cnt[32*i +: 32], 64'(gcnt[i]));
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    repeat (3) run_txn(3'b001, 0, 1'b1);
    check_eq("cnt0_three", grant_cnt[31:0], 64'd3);
    perf_clr = 1'b1;
    run_txn(3'b001, 0, 1'b1);
    perf_clr = 1'b0;
    check_eq("cnt0_clr", grant_cnt[31:0], 64'd0);
`else
    perf_clr = 1'b1;
    run_txn(3'b001, 0, 1'b1);
    perf_clr = 1'b0;
    check_eq("cnt_tied", grant_cnt, '0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
